// File: rtl/seg_msg_scheduler_pkg.sv
// seg_msg_pkg: message length, glyph patterns, state encoding and glyph ROM lookup
package seg_msg_pkg;
    localparam int MSG_LEN = 14;
    localparam logic [7:0] GLY_DP    = 8'h80;
    localparam logic [7:0] GLY_S     = 8'h5B;
    localparam logic [7:0] GLY_E     = 8'h4F;
    localparam logic [7:0] GLY_N     = 8'h15;
    localparam logic [7:0] GLY_O     = 8'h7E;
    localparam logic [7:0] GLY_L     = 8'h0E;
    localparam logic [7:0] GLY_G     = 8'h5F;
    localparam logic [7:0] GLY_U     = 8'h3E;
    localparam logic [7:0] GLY_BLANK = 8'h00;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;
    function automatic logic [7:0] glyph(input logic [3:0] i);
        case (i)
            4'd0:    return GLY_DP;
            4'd1:    return GLY_S;
            4'd2:    return GLY_E;
            4'd3:    return GLY_N;
            4'd4:    return GLY_O;
            4'd5:    return GLY_L;
            4'd6:    return GLY_G;
            4'd7:    return GLY_U;
            4'd8:    return GLY_L;
            4'd9:    return GLY_G;
            4'd10:   return GLY_O;
            4'd11:   return GLY_N;
            4'd12:   return GLY_U;
            4'd13:   return GLY_L;
            default: return GLY_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/seg_msg_scheduler_if.sv
// seg_msg_scheduler_if: control inputs and segment outputs of the message scheduler
interface seg_msg_scheduler_if;
    logic       ena;
    logic       btn_raw;
    logic       mode_auto;
    logic [2:0] speed;
    logic       hold;
    logic [7:0] seg_out;
    logic [3:0] char_idx;
    logic       frame_done;
    modport master (output ena, btn_raw, mode_auto, speed, hold, input seg_out, char_idx, frame_done);
    modport slave  (input ena, btn_raw, mode_auto, speed, hold, output seg_out, char_idx, frame_done);
endinterface

// File: rtl/seg_msg_scheduler_btn_debounce.sv
// btn_debounce: synchronizes a bouncy button and pulses once per accepted rising level
module btn_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic btn_pulse
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          flip;
    assign flip = sync[1] != stable && cnt == CW'(DEB_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync      <= '0;
            cnt       <= '0;
            stable    <= 1'b0;
            btn_pulse <= 1'b0;
        end else if (ena) begin
            sync      <= {sync[0], btn_raw};
            cnt       <= (sync[1] != stable && !flip) ? cnt + CW'(1) : '0;
            stable    <= flip ? sync[1] : stable;
            btn_pulse <= flip && sync[1];
        end
    end
endmodule

// File: rtl/seg_msg_scheduler.sv
// seg_msg_scheduler: steps a fixed 7-segment message on button presses or an auto-scroll tick
module seg_msg_scheduler
    import seg_msg_pkg::*;
#(
    parameter int SPD_BASE   = 20,
    parameter int DEB_CYCLES = 50000
) (
    input logic              clk,
    input logic              rst_n,
    seg_msg_scheduler_if.slave bus
);
    localparam int PW = SPD_BASE + 7;
    logic          btn_pulse, tick, adv, changed, mode_q;
    logic [2:0]    speed_q;
    logic [PW-1:0] pre, reload;
    state_t        state, state_d;
    logic [7:0]    seg, seg_d;
    logic [3:0]    idx, idx_d;
    logic          fd, fd_d;
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk, .rst_n, .ena(bus.ena), .btn_raw(bus.btn_raw), .btn_pulse
    );
    assign reload  = (PW'(1) << (SPD_BASE + int'(bus.speed))) - PW'(1);
    // a rate or mode change restarts the period instead of ticking
    assign changed = bus.speed != speed_q || bus.mode_auto != mode_q;
    assign tick    = bus.mode_auto && !bus.hold && !changed && pre == '0;
    assign adv     = btn_pulse | tick;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre     <= reload;
            speed_q <= bus.speed;
            mode_q  <= bus.mode_auto;
        end else if (bus.ena) begin
            pre     <= (changed || tick) ? reload : (bus.mode_auto && !bus.hold) ? pre - PW'(1) : pre;
            speed_q <= bus.speed;
            mode_q  <= bus.mode_auto;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            seg   <= GLY_BLANK;
            idx   <= '0;
            fd    <= 1'b0;
        end else if (bus.ena) begin
            state <= state_d;
            seg   <= seg_d;
            idx   <= idx_d;
            fd    <= fd_d;
        end
    end
    always_comb begin
        state_d = state;
        seg_d   = seg;
        idx_d   = idx;
        fd_d    = 1'b0;
        if (adv) begin
            if (state == RUN && idx == 4'(MSG_LEN - 1)) begin
                state_d = GAP;
                seg_d   = GLY_BLANK;
                fd_d    = 1'b1;
            end else begin
                state_d = RUN;
                idx_d   = state == RUN ? idx + 4'd1 : 4'd0;
                seg_d   = glyph(idx_d);
            end
        end
    end
    assign bus.seg_out    = seg;
    assign bus.char_idx   = idx;
    assign bus.frame_done = fd;
endmodule
